// File: rtl/ifu_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: defaults, FSM
// encoding, the bubble word and the IF/ID register layout.
package ifu_defs;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
   localparam int unsigned DEF_IM_DEPTH = 1024;

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
      logic        err;
   } ifid_t;

   // IF/ID contents for a bubble: the PC field is kept so ID still sees
   // where the pipe stopped.
   function automatic ifid_t ifid_bubble(input ifid_t cur);
      ifid_t r;
      r       = cur;
      r.instr = NOP;
      r.valid = 1'b0;
      r.err   = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/ifu_ctrl_pc_check.sv
// Combinational fetch-address check: flags a PC that is misaligned or lies
// outside the instruction ROM window.
module pc_check #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int unsigned IM_DEPTH = 1024
) (
   input  logic [31:0] pc,
   output logic        err
);

   localparam logic [31:0] LAST_PC = RESET_PC + 32'(4 * IM_DEPTH) - 32'd4;

   logic misaligned;
   logic below;
   logic above;

   always_comb begin
      misaligned = (pc[1:0] != 2'b00);
      below      = (pc < RESET_PC);
      above      = (pc > LAST_PC);
      err        = misaligned | below | above;
   end

endmodule

// File: rtl/ifu_ctrl.sv
// Fetch controller: owns the PC, registers the ROM word into IF/ID and
// handles stall, delayed-branch redirect, flush and fetch-error halt.
module ifu_ctrl
   import ifu_defs::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter int unsigned IM_DEPTH = DEF_IM_DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic [31:0] im_addr,
   input  logic [31:0] im_instr,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc8,
   output logic        ifid_valid,
   output logic        ifid_err,
   output logic        halted,
   output logic [31:0] fetch_cnt
);

   logic [31:0] pc_q, pc_d;
   ifid_t       ifid_q, ifid_d;
   logic [0:0]  state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        pc_bad;

   pc_check #(
      .RESET_PC (RESET_PC),
      .IM_DEPTH (IM_DEPTH)
   ) u_pc_check (
      .pc  (pc_q),
      .err (pc_bad)
   );

   // Priority: flush, halt hold, stall, error, normal fetch (reset in the flop).
   always_comb begin
      pc_d    = pc_q;
      ifid_d  = ifid_q;
      state_d = state_q;
      cnt_d   = cnt_q;

      if (flush) begin
         ifid_d  = ifid_bubble(ifid_q);
         pc_d    = flush_pc;
         state_d = ST_RUN;
      end else if (state_q == ST_HALT) begin
         ifid_d = ifid_bubble(ifid_q);
      end else if (stall) begin
         ifid_d = ifid_q;
      end else if (pc_bad) begin
         ifid_d.instr = NOP;
         ifid_d.pc    = pc_q;
         ifid_d.valid = 1'b1;
         ifid_d.err   = 1'b1;
         state_d      = ST_HALT;
         cnt_d        = cnt_q + 32'd1;
      end else begin
         // The word fetched alongside a redirect is the delay slot; keep it.
         ifid_d.instr = im_instr;
         ifid_d.pc    = pc_q;
         ifid_d.valid = 1'b1;
         ifid_d.err   = 1'b0;
         pc_d         = redirect_valid ? redirect_pc : (pc_q + 32'd4);
         cnt_d        = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         ifid_q.instr <= NOP;
         ifid_q.pc    <= 32'd0;
         ifid_q.valid <= 1'b0;
         ifid_q.err   <= 1'b0;
         state_q      <= ST_RUN;
         cnt_q        <= 32'd0;
      end else begin
         pc_q    <= pc_d;
         ifid_q  <= ifid_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign im_addr    = pc_q;
   assign ifid_instr = ifid_q.instr;
   assign ifid_pc    = ifid_q.pc;
   assign ifid_pc8   = ifid_q.pc + 32'd8;
   assign ifid_valid = ifid_q.valid;
   assign ifid_err   = ifid_q.err;
   assign halted     = (state_q == ST_HALT);
   assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_ifu_ctrl.sv
// Scoreboard bench for ifu_ctrl: directed scenarios then random traffic,
// checked against a behavioural fetch model.
module tb_ifu_ctrl;

   localparam logic [31:0] RPC   = 32'h0000_3000;
   localparam int          DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = 32'd0;
   logic [31:0] im_addr;
   logic [31:0] im_instr;
   logic [31:0] ifid_instr, ifid_pc, ifid_pc8, fetch_cnt;
   logic        ifid_valid, ifid_err, halted;

   logic [31:0] mem [DEPTH];

   always #5 clk = ~clk;

   ifu_ctrl #(.RESET_PC(RPC), .IM_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .flush_pc       (flush_pc),
      .im_addr        (im_addr),
      .im_instr       (im_instr),
      .ifid_instr     (ifid_instr),
      .ifid_pc        (ifid_pc),
      .ifid_pc8       (ifid_pc8),
      .ifid_valid     (ifid_valid),
      .ifid_err       (ifid_err),
      .halted         (halted),
      .fetch_cnt      (fetch_cnt)
   );

   // Instruction ROM: anything outside the window reads as garbage.
   logic [31:0] rom_off;
   always_comb begin
      rom_off  = im_addr - RPC;
      im_instr = 32'hBAD0_BAD0;
      if (im_addr >= RPC && rom_off < 32'(4 * DEPTH))
         im_instr = mem[rom_off[11:2]];
   end

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] ipc;
      logic        valid;
      logic        err;
      logic [31:0] cnt;
      logic        halt;
      logic        chk_pc;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [31:0] m_pc = RPC, m_instr = 0, m_ipc = 0, m_cnt = 0;
   logic        m_valid = 0, m_err = 0, m_halt = 0;

   function automatic bit addr_bad(input logic [31:0] a);
      return (a % 4 != 0) || (a < RPC) || (a >= RPC + 32'(4 * DEPTH));
   endfunction

   task automatic cycle(input bit rst, input bit st, input bit rv,
                        input logic [31:0] rpc, input bit fl,
                        input logic [31:0] fpc);
      exp_t e;
      bit   just_reset;
      @(negedge clk);
      reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc;
      flush = fl; flush_pc = fpc;
      just_reset = 0;
      if (rst) begin
         m_pc = RPC; m_instr = 0; m_ipc = 0; m_valid = 0; m_err = 0;
         m_cnt = 0; m_halt = 0; just_reset = 1;
      end else if (fl) begin
         m_instr = 0; m_valid = 0; m_err = 0; m_pc = fpc; m_halt = 0;
      end else if (m_halt) begin
         m_instr = 0; m_valid = 0; m_err = 0;
      end else if (!st) begin
         m_ipc = m_pc; m_valid = 1; m_cnt = m_cnt + 1;
         if (addr_bad(m_pc)) begin
            m_instr = 0; m_err = 1; m_halt = 1;
         end else begin
            m_instr = mem[(m_pc - RPC) / 4]; m_err = 0;
            m_pc = rv ? rpc : m_pc + 4;
         end
      end
      e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc; e.valid = m_valid;
      e.err = m_err; e.cnt = m_cnt; e.halt = m_halt;
      e.chk_pc = m_valid || just_reset;
      exp_q.push_back(e);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: compares DUT outputs after each edge against the queued model.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("im_addr", im_addr, e.pc);
            chk("ifid_valid", 32'(ifid_valid), 32'(e.valid));
            chk("ifid_err", 32'(ifid_err), 32'(e.err));
            chk("ifid_instr", ifid_instr, e.instr);
            chk("halted", 32'(halted), 32'(e.halt));
            chk("fetch_cnt", fetch_cnt, e.cnt);
            if (e.chk_pc) begin
               chk("ifid_pc", ifid_pc, e.ipc);
               chk("ifid_pc8", ifid_pc8, e.ipc + 32'd8);
            end
         end
      end
   end

   initial begin
      logic [31:0] tgt;
      int          r;
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

      // Reset then sequential fetch
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      run(2);
      // Stall with a pending redirect at PC=0x3008
      cycle(0, 1, 1, 32'h0000_3200, 0, 0);
      cycle(0, 1, 1, 32'h0000_3200, 0, 0);
      run(2);
      // Branch at PC=0x3010 to 0x3100 with delay slot
      cycle(0, 0, 1, 32'h0000_3100, 0, 0);
      run(2);
      // Out-of-range redirect, then halt ignores stall and redirect
      cycle(0, 0, 1, 32'h0000_4000, 0, 0);
      run(2);
      cycle(0, 1, 1, 32'h0000_3000, 0, 0);
      cycle(0, 0, 1, 32'h0000_3000, 0, 0);
      // Flush out of HALT while stalled
      cycle(0, 1, 0, 0, 1, 32'h0000_3080);
      run(1);
      // Misaligned and below-range errors
      cycle(0, 0, 1, 32'h0000_3102, 0, 0);
      run(2);
      cycle(0, 0, 0, 0, 1, 32'h0000_2FFC);
      run(2);
      cycle(0, 0, 0, 0, 1, 32'h0000_3FFC);
      run(3);
      // Reset while stalled with a nonzero count
      cycle(1, 0, 0, 0, 0, 0);
      run(5);
      cycle(0, 1, 0, 0, 0, 0);
      cycle(1, 1, 0, 0, 0, 0);
      run(1);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         r = int'($urandom_range(0, 99));
         tgt = RPC + 4 * $urandom_range(0, DEPTH - 1);
         case ($urandom_range(0, 19))
            0:       tgt = RPC + 32'(4 * DEPTH);
            1:       tgt = tgt | 32'd1;
            2:       tgt = RPC - 4;
            default: ;
         endcase
         cycle(r < 1, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
               tgt, (r >= 1 && r < 5) || (m_halt && r < 30), tgt);
      end
      run(2);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
